// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and single-port RAM signals of the memory arbiter.
interface mem_arbiter_if;
    logic        f_req;
    logic [8:0]  f_addr;
    logic        f_done;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_done, f_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_done, f_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM between a fetch and a data port, IDLE -> ACC -> RESP per access.
// Fixed data priority by default; define MEM_ARB_RR_EN for round-robin on collisions.
module mem_arbiter (
    input  logic          clk,
    input  logic          clr,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC_F, ACC_D, RESP} state_t;

    state_t      state, state_nx;
    logic        grant, pick_d, gnt_d, we_q;
    logic [8:0]  addr_q;
    logic [31:0] wdata_q, f_rdata_q, d_rdata_q;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;
    assign pick_d = bus.d_req && (!bus.f_req || rr_ptr);
    always_ff @(posedge clk or negedge clr)
        if (!clr)
            rr_ptr <= 1'b0;
        else if (grant)
            rr_ptr <= !pick_d;
`else
    assign pick_d = bus.d_req;
`endif

    assign grant = (state == IDLE) && (bus.f_req || bus.d_req);

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (pick_d ? ACC_D : bus.f_req ? ACC_F : IDLE)
                 : (state == RESP) ? IDLE : RESP;
    end

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                gnt_d  <= pick_d;
                addr_q <= pick_d ? bus.d_addr : bus.f_addr;
                we_q   <= pick_d && bus.d_we;
                if (pick_d)
                    wdata_q <= bus.d_wdata;
            end
            if (state == ACC_F)
                f_rdata_q <= bus.mem_rdata;
            if (state == ACC_D && !we_q)
                d_rdata_q <= bus.mem_rdata;
        end

    // strobes decode from state so an async reset kills them within the same cycle
    assign bus.mem_read  = (state == ACC_F) || (state == ACC_D && !we_q);
    assign bus.mem_write = (state == ACC_D) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.f_done    = (state == RESP) && !gnt_d;
    assign bus.d_done    = (state == RESP) && gnt_d;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural RAM.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] ram [512];

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk)
        if (bus.mem_write)
            ram[bus.mem_addr] <= bus.mem_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rd"}, bus.mem_read, 0);
        chk({tag, "_wr"}, bus.mem_write, 0);
        chk({tag, "_fdone"}, bus.f_done, 0);
        chk({tag, "_ddone"}, bus.d_done, 0);
        chk({tag, "_frdata"}, bus.f_rdata, 0);
        chk({tag, "_drdata"}, bus.d_rdata, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin
        int idx;
        logic exp_f, exp_d;
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[9'h005] = 32'h0980_0003;
        ram[9'h075] = 32'hdead_0075;
        bus.f_req = 0; bus.f_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        tick();
        chk_reset_outputs("reset");
        tick();
        clr = 1'b1;
        tick();

        // fetch alone
        bus.f_req = 1; bus.f_addr = 9'h005;
        tick();
        chk("f_acc_rd", bus.mem_read, 1);
        chk("f_acc_wr", bus.mem_write, 0);
        chk("f_acc_addr", bus.mem_addr, 9'h005);
        chk("f_acc_busy", bus.busy, 1);
        bus.f_req = 0;
        tick();
        chk("f_resp_done", bus.f_done, 1);
        chk("f_resp_ddone", bus.d_done, 0);
        chk("f_resp_rdata", bus.f_rdata, 32'h0980_0003);
        chk("f_resp_rd", bus.mem_read, 0);
        tick();
        chk("f_idle_done", bus.f_done, 0);
        chk("f_idle_busy", bus.busy, 0);
        chk("f_idle_addr_hold", bus.mem_addr, 9'h005);

        // store then load
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 9'h058; bus.d_wdata = 32'h66;
        tick();
        chk("st_acc_wr", bus.mem_write, 1);
        chk("st_acc_rd", bus.mem_read, 0);
        chk("st_acc_addr", bus.mem_addr, 9'h058);
        chk("st_acc_wdata", bus.mem_wdata, 32'h66);
        bus.d_req = 0;
        tick();
        chk("st_resp_wr", bus.mem_write, 0);
        chk("st_resp_done", bus.d_done, 1);
        chk("st_resp_drdata", bus.d_rdata, 0);
        chk("st_ram", ram[9'h058], 32'h66);
        tick();
        chk("st_idle_done", bus.d_done, 0);
        chk("st_idle_wdata_hold", bus.mem_wdata, 32'h66);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h058;
        tick();
        chk("ld_acc_rd", bus.mem_read, 1);
        chk("ld_acc_wr", bus.mem_write, 0);
        bus.d_req = 0;
        tick();
        chk("ld_resp_done", bus.d_done, 1);
        chk("ld_resp_drdata", bus.d_rdata, 32'h66);
        chk("ld_frdata_hold", bus.f_rdata, 32'h0980_0003);
        tick();

        // single collision
        bus.f_req = 1; bus.f_addr = 9'h005;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h075;
        tick();
`ifdef MEM_ARB_RR_EN
        chk("col_c1_addr", bus.mem_addr, 9'h005);
        bus.f_req = 0;
        tick();
        chk("col_c2_fdone", bus.f_done, 1);
        chk("col_c2_ddone", bus.d_done, 0);
        tick();
        tick();
        chk("col_c4_addr", bus.mem_addr, 9'h075);
        bus.d_req = 0;
        tick();
        chk("col_c5_ddone", bus.d_done, 1);
        chk("col_c5_fdone", bus.f_done, 0);
`else
        chk("col_c1_addr", bus.mem_addr, 9'h075);
        bus.d_req = 0;
        tick();
        chk("col_c2_ddone", bus.d_done, 1);
        chk("col_c2_fdone", bus.f_done, 0);
        tick();
        chk("col_c3_busy", bus.busy, 0);
        tick();
        chk("col_c4_addr", bus.mem_addr, 9'h005);
        bus.f_req = 0;
        tick();
        chk("col_c5_fdone", bus.f_done, 1);
        chk("col_c5_ddone", bus.d_done, 0);
`endif
        chk("col_drdata", bus.d_rdata, 32'hdead_0075);
        tick();

        // requester address change after grant
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h075;
        tick();
        bus.d_addr = 9'h000;
        #1;
        chk("addr_chg_acc", bus.mem_addr, 9'h075);
        bus.d_req = 0;
        tick();
        chk("addr_chg_resp", bus.mem_addr, 9'h075);
        chk("addr_chg_done", bus.d_done, 1);
        tick();

        // reset during a store access
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 9'h0a0; bus.d_wdata = 32'h1234;
        tick();
        chk("rst_acc_wr", bus.mem_write, 1);
        #2;
        clr = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        bus.d_req = 0;
        tick();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", bus.d_done, 0);
        end
        chk("rst_no_write", ram[9'h0a0], 0);

        // both requests held for 12 cycles
        bus.f_req = 1; bus.f_addr = 9'h005;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h058;
        idx = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_f = 0;
            exp_d = 0;
            if (i % 3 == 2) begin
`ifdef MEM_ARB_RR_EN
                exp_f = (idx % 2 == 0);
`else
                exp_f = 0;
`endif
                exp_d = !exp_f;
                idx++;
            end
            chk($sformatf("hold_c%0d_fdone", i), bus.f_done, exp_f);
            chk($sformatf("hold_c%0d_ddone", i), bus.d_done, exp_d);
        end
        bus.f_req = 0; bus.d_req = 0;
        tick();
        chk("hold_end_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- f_req  in  1  instruction-fetch request, level.
- f_addr  in  9  fetch word address.
- f_done  out  1  fetch complete, one-cycle pulse.
- f_rdata  out  32  fetched word.
- d_req  in  1  data request, level.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  9  data word address.
- d_wdata  in  32  store data.
- d_done  out  1  data access complete, one-cycle pulse.
- d_rdata  out  32  loaded word.
- mem_addr  out  9  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_rdata  in  32  RAM read data, combinational from mem_addr.
- busy  out  1  high in any state other than IDLE.

Function
REQ-002 The block SHALL implement a four-state FSM with states IDLE, ACC_F, ACC_D and RESP.
REQ-003 In IDLE, the block SHALL sample f_req and d_req and move to ACC_D or ACC_F per the priority rule; with no request it SHALL stay in IDLE.
REQ-004 On grant, the block SHALL latch the winner's address, plus d_we and d_wdata for a data grant, into internal registers; requester input changes after grant SHALL have no effect.
REQ-005 ACC_F and ACC_D SHALL each last exactly one cycle.
- mem_addr SHALL drive the latched address.
- mem_read SHALL be 1 for a fetch or load.
- mem_write SHALL be 1 for a store only.
- The read and write strobes SHALL never be high together.
REQ-006 At the end of an ACC cycle that performs a read, the block SHALL register mem_rdata into f_rdata or d_rdata.
REQ-007 A store SHALL leave d_rdata unchanged.
REQ-008 RESP SHALL last one cycle, pulse the granted port's done, and then return to IDLE.
REQ-009 Latency from a req first sampled in IDLE to done SHALL be exactly 2 cycles; the minimum issue interval is 3 cycles.
REQ-010 A req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-011 f_rdata and d_rdata SHALL hold their value until the next read of the same port.
REQ-012 Outside ACC states, mem_read and mem_write SHALL be 0; mem_addr and mem_wdata SHALL hold their last value.
REQ-013 All 9 address bits SHALL pass unmodified, with no range check and no wrap logic.
REQ-014 Fixed priority (default): when f_req and d_req are both high in IDLE, data SHALL win.

Reset
REQ-015 clr low SHALL immediately force the following, regardless of current state, including mid-ACC:
- state = IDLE.
- mem_read = mem_write = 0.
- f_done = d_done = 0; busy = 0.
- f_rdata = d_rdata = 0; mem_addr = 0; mem_wdata = 0.
- Round-robin pointer (when compiled in) = fetch-favoured.
REQ-016 An access interrupted by reset SHALL NOT complete or pulse done after clr is released; the requester SHALL re-issue it.

Configuration
REQ-017 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin.
- A one-bit pointer SHALL favour the port not granted last and update on every grant.
- After reset the pointer SHALL favour fetch.
REQ-018 Without MEM_ARB_RR_EN, REQ-014 fixed data priority SHALL apply and no pointer register SHALL exist.

Verification
REQ-019 Fetch alone: f_req=1, f_addr=9'h005, mem_rdata model returns 32'h0980_0003 -> mem_read=1 with mem_addr=5 in cycle 1; f_done=1 and f_rdata=32'h0980_0003 in cycle 2.
REQ-020 Store then load: d_we=1, d_addr=9'h058, d_wdata=32'h66 -> mem_write pulse of exactly 1 cycle; a later load from 9'h058 -> d_rdata=32'h66; d_rdata unchanged after the store.
REQ-021 Collision, fixed priority: f_req and d_req both high in IDLE -> ACC_D first with d_done in cycle 2, ACC_F next with f_done in cycle 5.
REQ-022 Collision, MEM_ARB_RR_EN defined, both requests held high for 12 cycles -> grants alternate F, D, F, D; 4 done pulses total.
REQ-023 Address change: d_addr changed from 9'h075 to 9'h000 during ACC_D -> mem_addr stays 9'h075.
REQ-024 Reset mid-operation: clr low during ACC_D of a store -> mem_write drops at once; no d_done pulse; busy=0; outputs equal the REQ-015 values.
